// File: rtl/shift_rotate_pkg.sv
// Shared types for the sequential shift/rotate engine.
// Opcode encoding, FSM states and the opcode legality check.
package shift_rotate_pkg;

   typedef enum logic [2:0] {
      OP_SHL  = 3'd0,
      OP_SHR  = 3'd1,
      OP_SAR  = 3'd2,
      OP_ROL  = 3'd3,
      OP_ROR  = 3'd4,
      OP_PASS = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= 3'd5);
   endfunction

endpackage

// File: rtl/shift_rotate_step.sv
// One-bit shift/rotate step, purely combinational.
// Illegal opcodes and PASS return the operand unchanged with no carry.
module shift_rotate_step
   import shift_rotate_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] data,
   input  logic [2:0]   opcode,
   output logic [W-1:0] next,
   output logic         carry
);

   // Select the single-bit move for the current opcode.
   always_comb begin
      next  = data;
      carry = 1'b0;
      unique case (opcode)
         OP_SHL: begin
            next  = {data[W-2:0], 1'b0};
            carry = data[W-1];
         end
         OP_SHR: begin
            next  = {1'b0, data[W-1:1]};
            carry = data[0];
         end
         OP_SAR: begin
            next  = {data[W-1], data[W-1:1]};
            carry = data[0];
         end
         OP_ROL: begin
            next  = {data[W-2:0], data[W-1]};
            carry = data[W-1];
         end
         OP_ROR: begin
            next  = {data[0], data[W-1:1]};
            carry = data[0];
         end
         default: begin
            next  = data;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate engine: one bit per clock, amount times.
// Optional carry/zero flag ports under SHIFT_ROTATE_SEQ_FLAGS_EN.
module shift_rotate_seq
   import shift_rotate_pkg::*;
#(
   parameter int W  = 8,
   parameter int AW = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [2:0]    in_opcode,
   input  logic [AW-1:0] in_amount,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
`ifdef SHIFT_ROTATE_SEQ_FLAGS_EN
   output logic          out_carry,
   output logic          out_zero,
`endif
   output logic          out_err
);

   state_e        state;
   state_e        state_nx;
   logic [W-1:0]  data_q;
   logic [2:0]    op_q;
   logic [AW-1:0] cnt_q;
   logic          err_q;
   logic          accept;
   logic          short_cmd;
   logic [W-1:0]  step_next;
   logic          step_carry;

   assign accept    = in_valid && (state == ST_IDLE);
   assign short_cmd = (in_amount == '0) ||
                      (in_opcode == OP_PASS) ||
                      !is_legal_op(in_opcode);

   shift_rotate_step #(.W(W)) u_step (
      .data   (data_q),
      .opcode (op_q),
      .next   (step_next),
      .carry  (step_carry)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (accept)
               state_nx = short_cmd ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (cnt_q <= AW'(1))
               state_nx = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Operand latch on accept, one step per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         op_q   <= 3'd0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         data_q <= in_data;
         op_q   <= in_opcode;
         cnt_q  <= in_amount;
         err_q  <= !is_legal_op(in_opcode);
      end else if (state == ST_RUN) begin
         data_q <= step_next;
         if (cnt_q != '0)
            cnt_q <= cnt_q - AW'(1);
      end
   end

   assign out_data = data_q;
   assign out_err  = err_q;

`ifdef SHIFT_ROTATE_SEQ_FLAGS_EN
   logic carry_q;

   // Last bit moved out; cleared on accept so short commands report 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                carry_q <= 1'b0;
      else if (accept)           carry_q <= 1'b0;
      else if (state == ST_RUN)  carry_q <= step_carry;
   end

   assign out_carry = out_valid && carry_q;
   assign out_zero  = out_valid && (data_q == '0);
`else
   logic unused_carry;
   assign unused_carry = step_carry;
`endif

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench for shift_rotate_seq: vector table plus
// back-pressure and mid-operation reset sequences.
module tb_shift_rotate_seq;
   import shift_rotate_pkg::*;

   localparam int W  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [2:0]    in_opcode;
   logic [AW-1:0] in_amount;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_err;
`ifdef SHIFT_ROTATE_SEQ_FLAGS_EN
   logic          out_carry;
   logic          out_zero;
`endif

   int total = 0;
   int bad   = 0;

   shift_rotate_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_opcode (in_opcode),
      .in_amount (in_amount),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef SHIFT_ROTATE_SEQ_FLAGS_EN
      .out_carry (out_carry),
      .out_zero  (out_zero),
`endif
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [2:0] op;
      logic [2:0] amt;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_lat;
      logic       exp_carry;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Issue a command, wait for the result; leaves it in DONE.
   task automatic issue(input logic [7:0] d, input logic [2:0] op,
                        input logic [2:0] amt, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_before_cmd", int'(in_ready), 1);
      in_valid  = 1'b1;
      in_data   = d;
      in_opcode = op;
      in_amount = amt;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      string n;
      issue(v.data, v.op, v.amt, lat);
      n = $sformatf("v%0d", idx);
      chk({n, "_valid"}, int'(out_valid), 1);
      chk({n, "_data"}, int'(out_data), int'(v.exp_data));
      chk({n, "_err"}, int'(out_err), int'(v.exp_err));
      chk({n, "_lat"}, lat, v.exp_lat);
`ifdef SHIFT_ROTATE_SEQ_FLAGS_EN
      chk({n, "_carry"}, int'(out_carry), int'(v.exp_carry));
      chk({n, "_zero"}, int'(out_zero), int'(v.exp_data == 8'h00));
`endif
      // out_ready is high, so the transfer happens on this edge.
      @(posedge clk);
      #1;
      chk({n, "_valid_drop"}, int'(out_valid), 0);
      chk({n, "_ready_back"}, int'(in_ready), 1);
      chk({n, "_data_keep"}, int'(out_data), int'(v.exp_data));
   endtask

   initial begin
      int lat;
      vecs[0]  = '{8'hB5, OP_SHL,  3'd3, 8'hA8, 1'b0, 4, 1'b1};
      vecs[1]  = '{8'hB5, OP_SAR,  3'd2, 8'hED, 1'b0, 3, 1'b0};
      vecs[2]  = '{8'hB5, OP_ROR,  3'd1, 8'hDA, 1'b0, 2, 1'b1};
      vecs[3]  = '{8'hB5, OP_ROL,  3'd4, 8'h5B, 1'b0, 5, 1'b1};
      vecs[4]  = '{8'hB5, OP_SHR,  3'd7, 8'h01, 1'b0, 8, 1'b0};
      vecs[5]  = '{8'hB5, OP_SHL,  3'd0, 8'hB5, 1'b0, 1, 1'b0};
      vecs[6]  = '{8'hB5, OP_PASS, 3'd5, 8'hB5, 1'b0, 1, 1'b0};
      vecs[7]  = '{8'h3C, 3'd6,    3'd3, 8'h3C, 1'b1, 1, 1'b0};
      vecs[8]  = '{8'h3C, OP_SHR,  3'd2, 8'h0F, 1'b0, 3, 1'b0};
      vecs[9]  = '{8'h3C, 3'd7,    3'd0, 8'h3C, 1'b1, 1, 1'b0};
      vecs[10] = '{8'h80, OP_SHL,  3'd1, 8'h00, 1'b0, 2, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_opcode = '0;
      in_amount = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_err", int'(out_err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_vec(vecs[i], i);

      // Back-pressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      issue(8'h0F, OP_SHL, 3'd2, lat);
      chk("bp_lat", lat, 3);
      chk("bp_valid", int'(out_valid), 1);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      in_opcode = OP_PASS;
      in_amount = 3'd0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", int'(out_valid), 1);
         chk("bp_hold_data", int'(out_data), 8'h3C);
         chk("bp_hold_err", int'(out_err), 0);
         chk("bp_hold_ready", int'(in_ready), 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_xfer_valid", int'(out_valid), 0);
      chk("bp_xfer_ready", int'(in_ready), 1);
      chk("bp_xfer_data", int'(out_data), 8'h3C);

      // Reset in the middle of a long shift.
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      in_opcode = OP_SHL;
      in_amount = 3'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("mid_in_run", int'(in_ready), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_data", int'(out_data), 0);
      chk("mid_rst_err", int'(out_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_ready", int'(in_ready), 1);
      repeat (9) @(posedge clk);
      #1;
      chk("mid_no_ghost", int'(out_valid), 0);
      run_vec('{8'h81, OP_SHL, 3'd7, 8'h80, 1'b0, 8, 1'b0}, 99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
